pio_in_edge_irq: RTL

PIO_IN_EDGE_IRQ -- requirements
Module: pio_in_edge_irq

---
 rtl/pio_pkg.sv | 10 +
 rtl/pio_debounce.sv | 28 ++
 rtl/pio_in_edge_irq.sv | 73 +++++++
 3 files changed

// File: rtl/pio_pkg.sv
// pio_pkg: register map and edge-mode encodings shared by the PIO edge-capture block.
package pio_pkg;
  localparam logic [1:0] ADDR_DATA = 2'd0;
  localparam logic [1:0] ADDR_RSVD = 2'd1;
  localparam logic [1:0] ADDR_MASK = 2'd2;
  localparam logic [1:0] ADDR_EDGE = 2'd3;
  localparam int EDGE_RISE = 0;
  localparam int EDGE_FALL = 1;
  localparam int EDGE_ANY  = 2;
endpackage

// File: rtl/pio_debounce.sv
// pio_debounce: one-bit debouncer; output follows input after DEBOUNCE_CYCLES consecutive differing cycles.
module pio_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic reset_n,
  input  logic d_i,
  output logic q_o
);
  logic [15:0] cnt_q, cnt_d;
  logic        q_q, q_d;
  logic        done;
  always_comb begin
    done  = (d_i != q_q) && (cnt_q == 16'(DEBOUNCE_CYCLES - 1));
    cnt_d = (d_i == q_q || done) ? 16'd0 : cnt_q + 16'd1;
    q_d   = done ? d_i : q_q;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q <= '0;
      q_q   <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      q_q   <= q_d;
    end
  end
  assign q_o = q_q;
endmodule

// File: rtl/pio_in_edge_irq.sv
// pio_in_edge_irq: synchronised input port with edge capture, irq mask and level interrupt.
// Define PIO_IN_DEBOUNCE_EN to insert a per-bit debouncer after the synchroniser.
module pio_in_edge_irq
  import pio_pkg::*;
#(
  parameter int WIDTH           = 18,
  parameter int EDGE_TYPE       = 1,
  parameter int SYNC_STAGES     = 2,
  parameter int BIT_CLEAR       = 1,
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);
  logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
  logic [WIDTH-1:0] stable, prev_q, detect, clr;
  logic [WIDTH-1:0] edge_q, edge_d, mask_q, mask_d;
  logic [31:0]      rdata_q, rdata_d;
  logic             irq_q, irq_d, wr;
`ifdef PIO_IN_DEBOUNCE_EN
  for (genvar g = 0; g < WIDTH; g++) begin : g_db
    pio_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk    (clk),
      .reset_n(reset_n),
      .d_i    (sync_q[SYNC_STAGES-1][g]),
      .q_o    (stable[g])
    );
  end
`else
  localparam int unused_debounce_cycles = DEBOUNCE_CYCLES;
  assign stable = sync_q[SYNC_STAGES-1];
`endif
  assign detect = (EDGE_TYPE == EDGE_RISE) ? (stable & ~prev_q) :
                  (EDGE_TYPE == EDGE_FALL) ? (~stable & prev_q) : (stable ^ prev_q);
  // A freshly detected edge wins over a clear landing on the same clock.
  always_comb begin
    sync_d  = {sync_q[SYNC_STAGES-2:0], in_port};
    wr      = chipselect && !write_n;
    clr     = (wr && address == ADDR_EDGE) ? ((BIT_CLEAR != 0) ? writedata[WIDTH-1:0] : '1) : '0;
    edge_d  = (edge_q & ~clr) | detect;
    mask_d  = (wr && address == ADDR_MASK) ? writedata[WIDTH-1:0] : mask_q;
    rdata_d = (address == ADDR_DATA) ? 32'(stable) :
              (address == ADDR_MASK) ? 32'(mask_q) :
              (address == ADDR_EDGE) ? 32'(edge_q) : 32'd0;
    irq_d   = |(edge_q & mask_q);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q  <= '0;
      prev_q  <= '0;
      edge_q  <= '0;
      mask_q  <= '0;
      rdata_q <= '0;
      irq_q   <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      prev_q  <= stable;
      edge_q  <= edge_d;
      mask_q  <= mask_d;
      rdata_q <= rdata_d;
      irq_q   <= irq_d;
    end
  end
  assign readdata = rdata_q;
  assign irq      = irq_q;
endmodule
